change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 136 +++++++++++++
 tb/tb_change_dispenser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy 10/5/1 payout from a refillable inventory,
// one coin per valid/ready handshake, with abort and a one-cycle done pulse.
module change_dispenser (
  input  logic        clock,
  input  logic        clear,
  input  logic        req,
  input  logic [31:0] amount,
  input  logic        abort,
  input  logic        refill_en,
  input  logic [7:0]  refill_10,
  input  logic [7:0]  refill_5,
  input  logic [7:0]  refill_1,
  input  logic        coin_ready,
  output logic        coin_valid,
  output logic [5:0]  coin_value,
  output logic        ready,
  output logic        done,
  output logic [31:0] paid_total,
  output logic [31:0] shortfall,
  output logic [7:0]  inv_10,
  output logic [7:0]  inv_5,
  output logic [7:0]  inv_1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PAY  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [31:0] remaining;
  logic [31:0] remaining_after;
  logic        hs;
  logic        dec_10, dec_5, dec_1;
  logic [5:0]  sel_value;
  logic        sel_ok;

  // Refill and handshake decrement can land on the same edge; clamp at 255.
  function automatic logic [7:0] inv_next(input logic [7:0] cur, input logic [7:0] add,
                                          input logic en, input logic dec);
    logic [8:0] sum;
    sum = {1'b0, cur} + (en ? {1'b0, add} : 9'd0) - {8'd0, dec};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign hs              = coin_valid & coin_ready & (state == PAY);
  assign dec_10          = hs & (coin_value == 6'd10);
  assign dec_5           = hs & (coin_value == 6'd5);
  assign dec_1           = hs & (coin_value == 6'd1);
  assign remaining_after = hs ? remaining - {26'd0, coin_value} : remaining;

  always_comb begin
    sel_value = '0;
    if (remaining >= 32'd10 && inv_10 != '0)
      sel_value = 6'd10;
    else if (remaining >= 32'd5 && inv_5 != '0)
      sel_value = 6'd5;
    else if (remaining >= 32'd1 && inv_1 != '0)
      sel_value = 6'd1;
  end
  assign sel_ok = (sel_value != '0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        state_next = IDLE;
        if (req) state_next = (amount != '0) ? PAY : DONE;
      end
      PAY: begin
        state_next = PAY;
        if (abort || (!coin_valid && !sel_ok)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      remaining  <= '0;
      paid_total <= '0;
      shortfall  <= '0;
      coin_valid <= 1'b0;
      coin_value <= '0;
      inv_10     <= '0;
      inv_5      <= '0;
      inv_1      <= '0;
    end else begin
      inv_10 <= inv_next(inv_10, refill_10, refill_en, dec_10);
      inv_5  <= inv_next(inv_5,  refill_5,  refill_en, dec_5);
      inv_1  <= inv_next(inv_1,  refill_1,  refill_en, dec_1);
      case (state)
        IDLE: begin
          if (req) begin
            remaining  <= amount;
            paid_total <= '0;
            if (amount == '0) shortfall <= '0;
          end
        end
        PAY: begin
          if (hs) begin
            remaining  <= remaining_after;
            paid_total <= paid_total + {26'd0, coin_value};
            coin_valid <= 1'b0;
          end
          // Abort reports what is left after a handshake on the same edge.
          if (abort) begin
            coin_valid <= 1'b0;
            shortfall  <= remaining_after;
          end else if (!coin_valid) begin
            if (sel_ok) begin
              coin_valid <= 1'b1;
              coin_value <= sel_value;
            end else begin
              shortfall <= remaining;
            end
          end
        end
        default: coin_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized payouts
// checked against a greedy arithmetic model of the coin inventory.
module tb_change_dispenser;

  logic        clock, clear, req, abort, refill_en, coin_ready;
  logic [31:0] amount;
  logic [7:0]  refill_10, refill_5, refill_1;
  logic        coin_valid, ready, done;
  logic [5:0]  coin_value;
  logic [31:0] paid_total, shortfall;
  logic [7:0]  inv_10, inv_5, inv_1;

  int n_cmp = 0;
  int n_err = 0;
  int m10 = 0, m5 = 0, m1 = 0;
  int exp_coins[$];
  int exp_paid, exp_sf, last_lat;

  change_dispenser dut (
    .clock(clock), .clear(clear), .req(req), .amount(amount), .abort(abort),
    .refill_en(refill_en), .refill_10(refill_10), .refill_5(refill_5), .refill_1(refill_1),
    .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_value(coin_value),
    .ready(ready), .done(done), .paid_total(paid_total), .shortfall(shortfall),
    .inv_10(inv_10), .inv_5(inv_5), .inv_1(inv_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_inv(input string tag);
    check({tag, "_inv10"}, {24'd0, inv_10}, m10);
    check({tag, "_inv5"},  {24'd0, inv_5},  m5);
    check({tag, "_inv1"},  {24'd0, inv_1},  m1);
  endtask

  task automatic do_refill(input int a10, input int a5, input int a1);
    refill_en = 1'b1;
    refill_10 = 8'(a10);
    refill_5  = 8'(a5);
    refill_1  = 8'(a1);
    step();
    refill_en = 1'b0;
    m10 = sat(m10 + a10);
    m5  = sat(m5 + a5);
    m1  = sat(m1 + a1);
    check_inv("refill");
  endtask

  task automatic pulse_clear();
    #2 clear = 1'b0;
    #1;
    check("clr_valid", {31'd0, coin_valid}, 0);
    check("clr_ready", {31'd0, ready}, 1);
    check("clr_done",  {31'd0, done}, 0);
    m10 = 0; m5 = 0; m1 = 0;
    check_inv("clr");
    #1 clear = 1'b1;
  endtask

  // Greedy payout as plain arithmetic over the model inventory.
  task automatic model_pay(input int amt);
    int rem;
    rem = amt;
    exp_coins.delete();
    exp_paid = 0;
    for (int k = 0; k < 1000; k++) begin
      if (rem >= 10 && m10 > 0)     begin exp_coins.push_back(10); m10--; end
      else if (rem >= 5 && m5 > 0)  begin exp_coins.push_back(5);  m5--;  end
      else if (rem >= 1 && m1 > 0)  begin exp_coins.push_back(1);  m1--;  end
      else break;
      rem      -= exp_coins[$];
      exp_paid += exp_coins[$];
    end
    exp_sf = rem;
  endtask

  // mode 0: coin_ready always 1; mode 1: random ready and stray req;
  // mode 2: first coin stalled for 3 cycles.
  task automatic run_pay(input int amt, input int mode);
    int         lat, stalls;
    logic       seen, stall_prev;
    logic [5:0] val_prev;
    logic [7:0] p10, p5, p1;
    logic [5:0] got[$];
    model_pay(amt);
    req = 1'b1; amount = amt; coin_ready = 1'b0;
    step();
    req = 1'b0;
    check("busy_ready", {31'd0, ready}, 0);
    seen = done; lat = 0; stalls = (mode == 2) ? 3 : 0;
    while (!seen && lat < 400) begin
      if (mode == 2 && coin_valid && stalls > 0) begin coin_ready = 1'b0; stalls--; end
      else if (mode == 1) coin_ready = 1'($urandom_range(0, 1));
      else coin_ready = 1'b1;
      if (mode == 1) begin req = 1'($urandom_range(0, 1)); amount = $urandom; end
      stall_prev = coin_valid && !coin_ready;
      val_prev = coin_value; p10 = inv_10; p5 = inv_5; p1 = inv_1;
      if (coin_valid && coin_ready) got.push_back(coin_value);
      step();
      lat++;
      if (stall_prev) begin
        check("hold_valid", {31'd0, coin_valid}, 1);
        check("hold_value", {26'd0, coin_value}, {26'd0, val_prev});
        check("hold_inv10", {24'd0, inv_10}, {24'd0, p10});
        check("hold_inv5",  {24'd0, inv_5},  {24'd0, p5});
        check("hold_inv1",  {24'd0, inv_1},  {24'd0, p1});
      end
      seen = done;
    end
    req = 1'b0; coin_ready = 1'b0;
    last_lat = lat;
    check("done_seen", {31'd0, seen}, 1);
    if (mode == 0) check("latency", lat, (amt == 0) ? 0 : 2 * exp_coins.size() + 1);
    if (mode == 2) check("stall_used", stalls, 0);
    check("paid", paid_total, exp_paid);
    check("shortfall", shortfall, exp_sf);
    check("done_novalid", {31'd0, coin_valid}, 0);
    check_inv("pay");
    check("n_coins", got.size(), exp_coins.size());
    for (int i = 0; i < got.size() && i < exp_coins.size(); i++)
      check("coin", {26'd0, got[i]}, exp_coins[i]);
    step();
    check("done_once", {31'd0, done}, 0);
    check("idle_ready", {31'd0, ready}, 1);
    check("sf_held", shortfall, exp_sf);
  endtask

  initial begin
    int pulses;
    clear = 1'b1; req = 1'b0; amount = '0; abort = 1'b0; refill_en = 1'b0;
    refill_10 = '0; refill_5 = '0; refill_1 = '0; coin_ready = 1'b0;
    #1 clear = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_valid", {31'd0, coin_valid}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_paid",  paid_total, 0);
    check("rst_sf",    shortfall, 0);
    check_inv("rst");
    step();
    clear = 1'b1;
    step();
    check("rel_ready", {31'd0, ready}, 1);
    check("rel_valid", {31'd0, coin_valid}, 0);

    // 27 from 3/3/5 with ready held high
    do_refill(3, 3, 5);
    run_pay(27, 0);
    check("p27_lat", last_lat, 11);
    check("p27_paid", paid_total, 27);
    check("p27_inv", {inv_10, inv_5, inv_1, 8'd0}, {8'd1, 8'd2, 8'd3, 8'd0});

    // shortfall: 15 from 0/1/2
    pulse_clear();
    do_refill(0, 1, 2);
    run_pay(15, 0);
    check("p15_paid", paid_total, 7);
    check("p15_sf", shortfall, 8);

    // first coin stalled for 3 cycles
    do_refill(3, 0, 0);
    run_pay(10, 2);

    // abort on the same edge as the first handshake
    req = 1'b1; amount = 20;
    step();
    req = 1'b0;
    step();
    check("ab_valid", {31'd0, coin_valid}, 1);
    check("ab_value", {26'd0, coin_value}, 10);
    coin_ready = 1'b1; abort = 1'b1;
    step();
    coin_ready = 1'b0; abort = 1'b0;
    m10 = m10 - 1;
    check("ab_done", {31'd0, done}, 1);
    check("ab_paid", paid_total, 10);
    check("ab_sf", shortfall, 10);
    check("ab_inv10", {24'd0, inv_10}, 1);
    check("ab_novalid", {31'd0, coin_valid}, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step(); if (done) pulses++; end
    check("ab_pulses", pulses, 0);

    // clear while a coin is presented
    req = 1'b1; amount = 10;
    step();
    req = 1'b0;
    step();
    check("mid_valid", {31'd0, coin_valid}, 1);
    pulse_clear();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step(); if (done) pulses++; end
    check("clr_pulses", pulses, 0);
    do_refill(2, 2, 2);
    run_pay(18, 0);

    // refill landing on a handshake edge: 1 + 5 - 1
    req = 1'b1; amount = 10;
    step();
    req = 1'b0;
    step();
    check("rh_value", {26'd0, coin_value}, 10);
    coin_ready = 1'b1; refill_en = 1'b1;
    refill_10 = 8'd5; refill_5 = '0; refill_1 = '0;
    step();
    coin_ready = 1'b0; refill_en = 1'b0;
    m10 = m10 + 5 - 1;
    check("rh_inv10", {24'd0, inv_10}, m10);
    step();
    check("rh_done", {31'd0, done}, 1);
    check("rh_paid", paid_total, 10);
    check("rh_sf", shortfall, 0);
    step();

    // saturation at 255
    do_refill(200, 200, 200);
    do_refill(100, 60, 55);
    run_pay(0, 0);

    // randomized payouts from small inventories
    pulse_clear();
    step();
    for (int it = 0; it < 24; it++) begin
      do_refill($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      run_pay(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
